// File: rtl/ps2_poly_synth.sv
// ps2_poly_synth: a polyphonic square-wave synthesizer that is driven by a PS/2 keyboard.
//
// The block reads the decoded scan-code byte stream and tracks make and break codes for
// eight note keys (A S D F G H J K). Each held key is assigned to one of VOICES
// square-wave oscillators. The voices that are high are counted, and that count is
// turned into a 1-bit sigma-delta stream for the speaker pin.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   code_byte    scan-code byte from the PS/2 receiver
//   code_valid   one-cycle strobe that qualifies code_byte
//   speaker      sigma-delta mixed audio output
//   voice_active bit v is set while voice v is sounding
//   held_keys    bit k is set while note key k owns a voice
//   mix_level    registered count of active voices whose square output is high

// One oscillator lane. It runs while `active` is set. When the count reaches hp-1,
// the counter wraps and the phase toggles. An idle lane is held at zero.
module ps2_voice_osc #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          active,
  input  logic [CW-1:0] hp,
  output logic          phase
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (alloc || !active) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == hp - CW'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
endmodule

module ps2_poly_synth #(
  parameter int CLK_HZ = 100_000_000,
  parameter int VOICES = 4,
  parameter int OCTAVE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   code_byte,
  input  logic                         code_valid,
  output logic                         speaker,
  output logic [VOICES-1:0]            voice_active,
  output logic [7:0]                   held_keys,
  output logic [$clog2(VOICES+1)-1:0]  mix_level
);
  // The lowest note (262 Hz, no octave shift) has the longest half-period, so it sets
  // the counter width.
  localparam int HP_MAX = CLK_HZ / (2 * 262);
  localparam int CW     = $clog2(HP_MAX + 1);
  localparam int MLW    = $clog2(VOICES + 1);
  localparam int AW     = $clog2(2 * VOICES);
  localparam int SW     = ((AW > MLW) ? AW : MLW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} dec_state_t;

  typedef struct packed {
    logic       make;
    logic       brk;
    logic [2:0] key;
  } key_ev_t;

  // Returns {hit, note_index}.
  function automatic logic [3:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C:   map_code = 4'b1_000;
      8'h1B:   map_code = 4'b1_001;
      8'h23:   map_code = 4'b1_010;
      8'h2B:   map_code = 4'b1_011;
      8'h34:   map_code = 4'b1_100;
      8'h33:   map_code = 4'b1_101;
      8'h3B:   map_code = 4'b1_110;
      8'h42:   map_code = 4'b1_111;
      default: map_code = 4'b0_000;
    endcase
  endfunction

  function automatic int half_period(input int base);
    return CLK_HZ / ((2 * base) << OCTAVE);
  endfunction

  // Every branch is a constant, so this reduces to a small lookup table.
  function automatic logic [CW-1:0] hp_of(input logic [2:0] k);
    case (k)
      3'd0:    hp_of = CW'(half_period(262));
      3'd1:    hp_of = CW'(half_period(294));
      3'd2:    hp_of = CW'(half_period(330));
      3'd3:    hp_of = CW'(half_period(349));
      3'd4:    hp_of = CW'(half_period(392));
      3'd5:    hp_of = CW'(half_period(440));
      3'd6:    hp_of = CW'(half_period(494));
      default: hp_of = CW'(half_period(523));
    endcase
  endfunction

  dec_state_t                  state_q, state_d;
  key_ev_t                     ev;
  logic [3:0]                  map_hit;
  logic [VOICES-1:0]           va_q, va_d;
  logic [VOICES-1:0][2:0]      vkey_q, vkey_d;
  logic [7:0]                  held_q, held_d;
  logic [VOICES-1:0]           alloc_vec;
  logic [VOICES-1:0]           free_oh;
  logic [VOICES-1:0]           brk_hit;
  logic                        free_found;
  logic [VOICES-1:0][CW-1:0]   hp_v;
  logic [VOICES-1:0]           phase_v;
  logic [MLW-1:0]              mix_q, mix_d;
  logic [AW-1:0]               acc_q, acc_d;
  logic                        spk_q, spk_d;
  logic [SW-1:0]               sum;

  // Scan-code decoder. One byte is consumed per strobe. An extended prefix (0xE0)
  // swallows the byte that follows it, and also swallows a following break sequence.
  always_comb begin
    state_d = state_q;
    ev      = '0;
    map_hit = map_code(code_byte);
    ev.key  = map_hit[2:0];
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code_byte == 8'hF0)      state_d = S_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else                         ev.make = map_hit[3];
        end
        S_BRK: begin
          state_d = S_IDLE;
          ev.brk  = map_hit[3];
        end
        S_EXT:    state_d = (code_byte == 8'hF0) ? S_EXTBRK : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Voice allocator. A make takes the lowest free voice. A break frees the voice that
  // holds the key. A make for a key that is already held is a typematic repeat and is
  // ignored.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    brk_hit    = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (!va_q[v] && !free_found) begin
        free_oh[v] = 1'b1;
        free_found = 1'b1;
      end
      brk_hit[v] = va_q[v] && (vkey_q[v] == ev.key);
    end

    va_d      = va_q;
    vkey_d    = vkey_q;
    held_d    = held_q;
    alloc_vec = '0;
    if (ev.make && !held_q[ev.key] && free_found) begin
      alloc_vec          = free_oh;
      held_d[ev.key]     = 1'b1;
      for (int v = 0; v < VOICES; v++) begin
        if (free_oh[v]) begin
          va_d[v]   = 1'b1;
          vkey_d[v] = ev.key;
        end
      end
    end else if (ev.brk && held_q[ev.key]) begin
      va_d           = va_q & ~brk_hit;
      held_d[ev.key] = 1'b0;
    end
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) hp_v[v] = hp_of(vkey_q[v]);
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    ps2_voice_osc #(.CW(CW)) u_osc (
      .clk    (clk),
      .rst    (rst),
      .alloc  (alloc_vec[v]),
      .active (va_q[v]),
      .hp     (hp_v[v]),
      .phase  (phase_v[v])
    );
  end

  // Registered popcount of the voices that are sounding high.
  always_comb begin
    mix_d = '0;
    for (int v = 0; v < VOICES; v++) mix_d = mix_d + MLW'(phase_v[v] & va_q[v]);
  end

  // First-order sigma-delta. The accumulator always stays below VOICES, so the sum
  // fits in SW bits and the accumulator does not overflow.
  always_comb begin
    sum = SW'(acc_q) + SW'(mix_q);
    if (sum >= SW'(VOICES)) begin
      spk_d = 1'b1;
      acc_d = AW'(sum - SW'(VOICES));
    end else begin
      spk_d = 1'b0;
      acc_d = AW'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      vkey_q  <= '0;
      held_q  <= '0;
      mix_q   <= '0;
      acc_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      vkey_q  <= vkey_d;
      held_q  <= held_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
    end
  end

  assign speaker      = spk_q;
  assign voice_active = va_q;
  assign held_keys    = held_q;
  assign mix_level    = mix_q;
endmodule

// File: tb/tb_ps2_poly_synth.sv
module tb_ps2_poly_synth;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_byte = 8'h00;
  logic       code_valid = 1'b0;

  logic       speaker, speaker2;
  logic [3:0] voice_active, voice_active2;
  logic [7:0] held_keys, held_keys2;
  logic [2:0] mix_level, mix_level2;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {voice_active, held_keys}.
  logic [11:0] exp_q[$];

  // Reference model state.
  int       m_state;
  bit [3:0] m_va;
  int       m_vkey[4];
  bit [7:0] m_held;

  always #5 clk = ~clk;

  ps2_poly_synth #(.CLK_HZ(1_000_000), .VOICES(4), .OCTAVE(0)) dut (
    .clk(clk), .rst(rst), .code_byte(code_byte), .code_valid(code_valid),
    .speaker(speaker), .voice_active(voice_active), .held_keys(held_keys),
    .mix_level(mix_level)
  );

  ps2_poly_synth #(.CLK_HZ(1_000_000), .VOICES(4), .OCTAVE(1)) dut_oct (
    .clk(clk), .rst(rst), .code_byte(code_byte), .code_valid(code_valid),
    .speaker(speaker2), .voice_active(voice_active2), .held_keys(held_keys2),
    .mix_level(mix_level2)
  );

  function automatic int key_idx(input logic [7:0] b);
    case (b)
      8'h1C: return 0; 8'h1B: return 1; 8'h23: return 2; 8'h2B: return 3;
      8'h34: return 4; 8'h33: return 5; 8'h3B: return 6; 8'h42: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    bit done;
    k = key_idx(b);
    case (m_state)
      0: begin
        if (b == 8'hF0) m_state = 1;
        else if (b == 8'hE0) m_state = 2;
        else if (k >= 0 && !m_held[k]) begin
          done = 0;
          for (int v = 0; v < 4; v++)
            if (!done && !m_va[v]) begin
              m_va[v] = 1; m_vkey[v] = k; m_held[k] = 1; done = 1;
            end
        end
      end
      1: begin
        m_state = 0;
        if (k >= 0 && m_held[k]) begin
          for (int v = 0; v < 4; v++)
            if (m_va[v] && m_vkey[v] == k) m_va[v] = 0;
          m_held[k] = 0;
        end
      end
      2: m_state = (b == 8'hF0) ? 3 : 0;
      default: m_state = 0;
    endcase
  endtask

  // This task is called at a negedge. It strobes one byte and returns at the following
  // negedge, so calls made back to back produce strobes on consecutive cycles.
  task automatic send_byte(input logic [7:0] b);
    logic [11:0] e;
    code_byte  = b;
    code_valid = 1'b1;
    model_byte(b);
    exp_q.push_back({m_va, m_held});
    @(negedge clk);
    code_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (voice_active !== e[11:8]) begin
      errors++;
      $display("FAIL sb_voice_active byte %h: got %b expected %b", b, voice_active, e[11:8]);
    end
    checks++;
    if (held_keys !== e[7:0]) begin
      errors++;
      $display("FAIL sb_held_keys byte %h: got %h expected %h", b, held_keys, e[7:0]);
    end
    checks++;
    if (voice_active2 !== e[11:8] || held_keys2 !== e[7:0]) begin
      errors++;
      $display("FAIL sb_oct_alloc byte %h: got %b/%h expected %b/%h", b, voice_active2,
               held_keys2, e[11:8], e[7:0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    code_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_state = 0; m_va = '0; m_held = '0;
    for (int v = 0; v < 4; v++) m_vkey[v] = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({speaker, voice_active, held_keys, mix_level} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got spk=%b va=%b hk=%h mix=%0d expected all 0",
               speaker, voice_active, held_keys, mix_level);
    end
    checks++;
    if ({speaker2, voice_active2, held_keys2, mix_level2} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state_oct: got spk=%b va=%b hk=%h mix=%0d expected all 0",
               speaker2, voice_active2, held_keys2, mix_level2);
    end
  endtask

  // This task counts negedges until the mix level reaches `target`. It returns the
  // count, or -1 if the wait times out.
  task automatic wait_mix(input bit oct, input int target, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((oct ? mix_level2 : mix_level) != 3'(target)) && n < budget);
    if (n >= budget) n = -1;
  endtask

  task automatic test_single_note();
    int n, ones_lo, ones_hi;
    do_reset();
    send_byte(8'h33);
    // The phase toggles HP edges after allocation. The mix level follows one edge later.
    wait_mix(0, 1, 3000, n);
    checks++;
    if (n != 1137) begin
      errors++;
      $display("FAIL h_first_toggle: got %0d cycles expected 1137", n);
    end
    wait_mix(0, 0, 3000, n);
    checks++;
    if (n != 1136) begin
      errors++;
      $display("FAIL h_half_period: got %0d cycles expected 1136", n);
    end
    ones_lo = 0;
    ones_hi = 0;
    for (int i = 0; i < 1136; i++) begin
      @(negedge clk);
      ones_lo += int'(speaker);
    end
    for (int i = 0; i < 1136; i++) begin
      @(negedge clk);
      ones_hi += int'(speaker);
    end
    checks++;
    if (ones_lo != 0) begin
      errors++;
      $display("FAIL density_low: got %0d ones expected 0", ones_lo);
    end
    checks++;
    if (ones_hi != 284) begin
      errors++;
      $display("FAIL density_high: got %0d ones expected 284", ones_hi);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    send_byte(8'h33);
    send_byte(8'h33);
    send_byte(8'h33);
    send_byte(8'hF0);
    send_byte(8'h33);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({speaker, mix_level, voice_active, held_keys} !== 16'h0) begin
      errors++;
      $display("FAIL break_silence: got spk=%b mix=%0d va=%b hk=%h expected all 0",
               speaker, mix_level, voice_active, held_keys);
    end
  endtask

  task automatic test_voice_alloc();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'h23);
    send_byte(8'h2B);
    send_byte(8'h34);
    checks++;
    if (voice_active !== 4'hF || held_keys !== 8'h0F) begin
      errors++;
      $display("FAIL full_drop: got va=%b hk=%h expected 1111/0f", voice_active, held_keys);
    end
    send_byte(8'hF0);
    send_byte(8'h1B);
    send_byte(8'h34);
    checks++;
    if (voice_active !== 4'hF || held_keys !== 8'h1D) begin
      errors++;
      $display("FAIL reuse_voice: got va=%b hk=%h expected 1111/1d", voice_active, held_keys);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++;
    if (voice_active !== 4'h0) begin
      errors++;
      $display("FAIL ext_ignored: got va=%b expected 0000", voice_active);
    end
    send_byte(8'h1C);
    checks++;
    if (voice_active !== 4'h1 || held_keys !== 8'h01) begin
      errors++;
      $display("FAIL ext_then_make: got va=%b hk=%h expected 0001/01", voice_active, held_keys);
    end
  endtask

  task automatic test_full_mix_reset();
    int n;
    int bad;
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'h23);
    send_byte(8'h2B);
    wait_mix(0, 4, 5000, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL mix_full_timeout: got mix=%0d expected 4", mix_level);
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (speaker !== 1'b1 || mix_level !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL speaker_stuck_high: got %0d bad cycles expected 0", bad);
    end
    // A single-cycle reset while a note is sounding.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({speaker, voice_active, held_keys, mix_level} !== 16'h0) begin
      errors++;
      $display("FAIL mid_note_reset: got spk=%b va=%b hk=%h mix=%0d expected all 0",
               speaker, voice_active, held_keys, mix_level);
    end
    m_state = 0; m_va = '0; m_held = '0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (speaker !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d speaker ones expected 0", bad);
    end
  endtask

  task automatic test_octave();
    int n;
    do_reset();
    send_byte(8'h1C);
    wait_mix(1, 1, 3000, n);
    checks++;
    if (n != 955) begin
      errors++;
      $display("FAIL oct_first_toggle: got %0d cycles expected 955", n);
    end
    wait_mix(1, 0, 3000, n);
    checks++;
    if (n != 954) begin
      errors++;
      $display("FAIL oct_half_period: got %0d cycles expected 954", n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single_note();
    test_typematic();
    test_voice_alloc();
    test_extended();
    test_full_mix_reset();
    test_octave();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
